writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final (WB) stage of the five-stage MIPS pipeline; write-side counterpart of the register file.
- Holds the MEM/WB pipeline register and selects the ALU result or the load data.
- Extracts and sign/zero-extends sub-word loads.
- Drives the register-file write port (data plus destination address, where address 0 means no write).
- Stalls upstream while a load waits for variable-latency memory read data.

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- i_clk  input  1  rising-edge clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  MEM stage offers an instruction this cycle.
- i_reg_write  input  1  instruction writes a GPR.
- i_mem_to_reg  input  1  1 = load (data from memory), 0 = ALU result.
- i_load_type  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW.
- i_dest  input  5  destination GPR.
- i_alu_result  input  32  ALU result; bits [1:0] give the load byte offset.
- i_mem_rdata  input  32  memory read word, little-endian.
- i_mem_rvalid  input  1  i_mem_rdata valid this cycle.
- o_wb_data  output  32  register-file write data.
- o_mux_addr  output  5  register-file write address; 0 means no write.
- o_stall  output  1  hold the MEM stage; i_valid is ignored while high.
- o_pend_valid  output  1  load pending (for the hazard unit).
- o_pend_dest  output  5  destination of the pending load.
- o_retire_count  output  CNT_W  instructions completed since reset.
- o_err  output  1  sticky: spurious rvalid or misaligned halfword.

Behaviour:
- Reset (async, i_reset_n=0):
  - state EMPTY; all internal registers 0.
  - o_wb_data=0, o_mux_addr=0, o_stall=0, o_pend_valid=0, o_pend_dest=0, o_retire_count=0, o_err=0.
- States: EMPTY, ALU, LOAD_WAIT, LOAD_DONE.
- Accept: at a posedge where o_stall=0 and i_valid=1, latch all i_* instruction fields into the WB register.
  - mem_to_reg=1 → next state LOAD_WAIT.
  - mem_to_reg=0 → next state ALU.
  - From EMPTY, ALU or LOAD_DONE with i_valid=0 → EMPTY.
- LOAD_WAIT:
  - o_stall=1, o_mux_addr=0, o_pend_valid=reg_write, o_pend_dest=dest.
  - On a posedge with i_mem_rvalid=1: latch extracted data and go to LOAD_DONE.
  - Otherwise stay; no timeout.
- Write presentation (ALU and LOAD_DONE):
  - o_mux_addr = dest if reg_write and dest≠0, else 0.
  - o_wb_data = alu_result (ALU) or the latched extracted data (LOAD_DONE).
  - Outputs are driven from registers, so they are stable for the whole cycle; the register file writes at the closing edge.
  - o_stall=0, so the next instruction may be accepted on the same edge.
- In EMPTY and LOAD_WAIT: o_mux_addr=0 and o_wb_data holds its last value.
- Latency:
  - Non-load accepted at edge N: write presented in cycle N..N+1, one cycle.
  - Load: rvalid sampled at edge M (M>N) → write presented the following cycle.
  - Minimum load latency is 2 cycles.
- o_retire_count: +1 on each posedge leaving ALU or LOAD_DONE, including dest=0 and reg_write=0. Wraps modulo 2^CNT_W.
- Load extraction, with off = alu_result[1:0]:
  - LB/LBU select byte rdata[8*off+7:8*off].
  - LH/LHU select halfword rdata[16*off[1]+15:16*off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW ignores off.
- Misaligned LH/LHU (off[0]=1): set o_err; use the off[1] halfword anyway.
- i_mem_rvalid=1 in any state other than LOAD_WAIT: set o_err; data ignored; no state change.
- o_err clears only on reset.
- Reset during LOAD_WAIT abandons the load: no write, and later rvalid counts as spurious.
- i_valid while o_stall=1 is not accepted; upstream must hold it.

Decomposition:
- writeback_pkg holds:
  - load-type constants LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU;
  - state encoding (2-bit) for EMPTY, ALU, LOAD_WAIT, LOAD_DONE.
- One combinational sub-module, load_extract: inputs rdata, offset, load_type; outputs 32-bit data and misalign flag. Unit-testable alone.

Test Plan:
- ALU write: accept reg_write=1, dest=5, alu=0xDEADBEEF → next cycle o_mux_addr=5, o_wb_data=0xDEADBEEF. Then, with i_valid=0, o_mux_addr=0; retire_count=1.
- dest=0 ALU op, alu=0x1234 → o_mux_addr stays 0 every cycle; retire_count increments to 1.
- LB, off=3, rdata=0x80FF1234, rvalid 3 cycles after accept:
  - o_stall=1, o_pend_valid=1, o_pend_dest=dest for those 3 cycles, with o_mux_addr=0;
  - then o_wb_data=0xFFFFFF80.
  - Repeat with LBU → 0x00000080, LH off=2 → 0xFFFF80FF, LHU off=2 → 0x000080FF.
- Load followed by ALU (dest=7, alu=0x55) held at i_valid during stall:
  - ALU is accepted on the edge entering LOAD_DONE's exit;
  - writes appear in consecutive cycles, load dest then 7;
  - retire_count=2.
- Assert i_reset_n=0 while in LOAD_WAIT → outputs all 0 immediately; after release, rvalid pulse → no write, o_err=1.
- LH with off=1 → o_err=1, data from halfword 0. Spurious rvalid in EMPTY on a fresh reset → o_err=1, no write.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared constants for the MIPS writeback stage: load-type codes and FSM encoding.
package writeback_pkg;

  // Load-type codes as driven by the MEM stage; 5-7 fall back to a full word.
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StAlu      = 2'd1,
    StLoadWait = 2'd2,
    StLoadDone = 2'd3
  } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// Sub-word load extraction from a little-endian 32-bit memory word.
module load_extract
  import writeback_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword, then extend according to the load type.
  always_comb begin
    unique case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // A misaligned halfword still uses the halfword chosen by offset bit 1.
    half_sel   = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    misalign_o = 1'b0;
    case (load_type_i)
      LT_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = offset_i[0];
      end
      LT_LHU: begin
        data_o     = {16'h0000, half_sel};
        misalign_o = offset_i[0];
      end
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'h000000, byte_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MIPS WB stage: MEM/WB register, load completion wait, and register-file write port.
module writeback_stage
  import writeback_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [2:0]        i_load_type,
  input  logic [4:0]        i_dest,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [4:0]        o_mux_addr,
  output logic              o_stall,
  output logic              o_pend_valid,
  output logic [4:0]        o_pend_dest,
  output logic [CNT_W-1:0]  o_retire_count,
  output logic              o_err
);

  wb_state_e         state_q, state_d;
  logic              reg_write_q, reg_write_d;
  logic [2:0]        load_type_q, load_type_d;
  logic [4:0]        dest_q, dest_d;
  logic [1:0]        offset_q, offset_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              err_q, err_d;

  logic              accept;
  logic              presenting;
  logic [31:0]       ext_data;
  logic              ext_misalign;

  // Offset comes from the latched address so extraction matches the load being completed.
  load_extract u_load_extract (
    .rdata_i     (i_mem_rdata),
    .offset_i    (offset_q),
    .load_type_i (load_type_q),
    .data_o      (ext_data),
    .misalign_o  (ext_misalign)
  );

  assign accept     = (state_q != StLoadWait) && i_valid;
  assign presenting = (state_q == StAlu) || (state_q == StLoadDone);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: every non-waiting state is a one-cycle slot that accepts or drains.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadWait: if (i_mem_rvalid) state_d = StLoadDone;
      default: begin
        if (i_valid) state_d = i_mem_to_reg ? StLoadWait : StAlu;
        else         state_d = StEmpty;
      end
    endcase
  end

  // MEM/WB register, write data, retire counter and sticky error.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      reg_write_q <= 1'b0;
      load_type_q <= 3'd0;
      dest_q      <= 5'd0;
      offset_q    <= 2'd0;
      wb_data_q   <= '0;
      retire_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      load_type_q <= load_type_d;
      dest_q      <= dest_d;
      offset_q    <= offset_d;
      wb_data_q   <= wb_data_d;
      retire_q    <= retire_d;
      err_q       <= err_d;
    end
  end

  // Datapath next-state; wb_data only changes when a new result becomes available.
  always_comb begin
    reg_write_d = reg_write_q;
    load_type_d = load_type_q;
    dest_d      = dest_q;
    offset_d    = offset_q;
    wb_data_d   = wb_data_q;
    retire_d    = retire_q;
    err_d       = err_q;
    if (accept) begin
      reg_write_d = i_reg_write;
      load_type_d = i_load_type;
      dest_d      = i_dest;
      offset_d    = i_alu_result[1:0];
      if (!i_mem_to_reg) wb_data_d = i_alu_result;
    end
    if (i_mem_rvalid) begin
      if (state_q == StLoadWait) begin
        wb_data_d = ext_data;
        if (ext_misalign) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // Each presenting slot lasts exactly one cycle, so every edge in it retires one.
    if (presenting) retire_d = retire_q + CNT_W'(1);
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_wb_data      = wb_data_q;
    o_mux_addr     = (presenting && reg_write_q && (dest_q != 5'd0)) ? dest_q : 5'd0;
    o_stall        = (state_q == StLoadWait);
    o_pend_valid   = (state_q == StLoadWait) && reg_write_q;
    o_pend_dest    = (state_q == StLoadWait) ? dest_q : 5'd0;
    o_retire_count = retire_q;
    o_err          = err_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a write-port scoreboard.
module tb_writeback_stage;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic        reg_write;
  logic        mem_to_reg;
  logic [2:0]  load_type;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] wb_data;
  logic [4:0]  mux_addr;
  logic        stall;
  logic        pend_valid;
  logic [4:0]  pend_dest;
  logic [31:0] retire_count;
  logic        err;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  exp_retire = 0;

  writeback_stage #(.DATA_W(32), .CNT_W(32)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_valid        (valid),
    .i_reg_write    (reg_write),
    .i_mem_to_reg   (mem_to_reg),
    .i_load_type    (load_type),
    .i_dest         (dest),
    .i_alu_result   (alu_result),
    .i_mem_rdata    (mem_rdata),
    .i_mem_rvalid   (mem_rvalid),
    .o_wb_data      (wb_data),
    .o_mux_addr     (mux_addr),
    .o_stall        (stall),
    .o_pend_valid   (pend_valid),
    .o_pend_dest    (pend_dest),
    .o_retire_count (retire_count),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && mux_addr != 5'd0) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_write", {27'd0, mux_addr}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", {27'd0, mux_addr}, {27'd0, e.addr});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rw, input logic m2r, input logic [2:0] lt,
                           input logic [4:0] d, input logic [31:0] alu);
    valid      = 1'b1;
    reg_write  = rw;
    mem_to_reg = m2r;
    load_type  = lt;
    dest       = d;
    alu_result = alu;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    tick();
    reset_n = 1'b1;
    exp_retire = 0;
  endtask

  // Load with rvalid three cycles after acceptance, checking the stall window.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                         input logic [4:0] d, input logic [31:0] rdata,
                         input logic [31:0] exp);
    set_instr(1'b1, 1'b1, lt, d, {30'h0000_0400, off});
    tick();
    valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_pend_valid"}, {31'd0, pend_valid}, 32'd1);
      chk({tag, "_pend_dest"}, {27'd0, pend_dest}, {27'd0, d});
      chk({tag, "_addr_wait"}, {27'd0, mux_addr}, 32'd0);
      if (c < 2) tick();
    end
    mem_rdata  = rdata;
    mem_rvalid = 1'b1;
    exp_q.push_back('{addr: d, data: exp});
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_nostall"}, {31'd0, stall}, 32'd0);
    tick();
    exp_retire++;
  endtask

  initial begin
    reset_n    = 1'b0;
    valid      = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    load_type  = 3'd0;
    dest       = 5'd0;
    alu_result = 32'd0;
    mem_rdata  = 32'd0;
    mem_rvalid = 1'b0;
    tick();
    tick();
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", {27'd0, mux_addr}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pend", {26'd0, pend_valid, pend_dest}, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU write to r5.
    set_instr(1'b1, 1'b0, 3'd0, 5'd5, 32'hDEAD_BEEF);
    exp_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
    tick();
    valid = 1'b0;
    chk("alu_addr", {27'd0, mux_addr}, 32'd5);
    chk("alu_data", wb_data, 32'hDEAD_BEEF);
    tick();
    exp_retire++;
    chk("alu_idle_addr", {27'd0, mux_addr}, 32'd0);
    chk("alu_hold_data", wb_data, 32'hDEAD_BEEF);
    chk("alu_retire", retire_count, exp_retire);

    // ALU op to r0: no write, still retires.
    set_instr(1'b1, 1'b0, 3'd0, 5'd0, 32'h0000_1234);
    tick();
    valid = 1'b0;
    chk("r0_addr", {27'd0, mux_addr}, 32'd0);
    tick();
    exp_retire++;
    chk("r0_addr_after", {27'd0, mux_addr}, 32'd0);
    chk("r0_retire", retire_count, exp_retire);

    // Sub-word loads from 0x80FF1234.
    do_load("lb",  3'd3, 2'd3, 5'd10, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 2'd3, 5'd11, 32'h80FF_1234, 32'h0000_0080);
    do_load("lh",  3'd1, 2'd2, 5'd12, 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("lhu", 3'd2, 2'd2, 5'd13, 32'h80FF_1234, 32'h0000_80FF);
    do_load("lw",  3'd0, 2'd1, 5'd14, 32'h80FF_1234, 32'h80FF_1234);
    chk("loads_retire", retire_count, exp_retire);
    chk("loads_no_err", {31'd0, err}, 32'd0);

    // Load followed by an ALU op held upstream during the stall.
    set_instr(1'b1, 1'b1, 3'd0, 5'd9, 32'h0000_0100);
    tick();
    set_instr(1'b1, 1'b0, 3'd0, 5'd7, 32'h0000_0055);
    tick();
    chk("held_stall", {31'd0, stall}, 32'd1);
    chk("held_addr_wait", {27'd0, mux_addr}, 32'd0);
    mem_rdata  = 32'hCAFE_F00D;
    mem_rvalid = 1'b1;
    exp_q.push_back('{addr: 5'd9, data: 32'hCAFE_F00D});
    exp_q.push_back('{addr: 5'd7, data: 32'h0000_0055});
    tick();
    mem_rvalid = 1'b0;
    chk("held_load_addr", {27'd0, mux_addr}, 32'd9);
    tick();
    valid = 1'b0;
    chk("held_alu_addr", {27'd0, mux_addr}, 32'd7);
    chk("held_alu_data", wb_data, 32'h0000_0055);
    tick();
    exp_retire += 2;
    chk("held_retire", retire_count, exp_retire);

    // Reset while waiting on a load abandons it.
    set_instr(1'b1, 1'b1, 3'd0, 5'd3, 32'h0000_0200);
    tick();
    valid = 1'b0;
    chk("abort_stall_before", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_wb_data", wb_data, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_pend", {26'd0, pend_valid, pend_dest}, 32'd0);
    chk("abort_retire", retire_count, 32'd0);
    tick();
    reset_n = 1'b1;
    exp_retire = 0;
    tick();
    mem_rdata  = 32'h1111_1111;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("abort_addr", {27'd0, mux_addr}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd1);
    tick();
    chk("abort_err_sticky", {31'd0, err}, 32'd1);

    // Misaligned LH: error flagged, halfword 0 used, minimum latency.
    do_reset();
    chk("mis_err_clear", {31'd0, err}, 32'd0);
    set_instr(1'b1, 1'b1, 3'd1, 5'd4, 32'h0000_0301);
    tick();
    valid = 1'b0;
    chk("mis_err_pre", {31'd0, err}, 32'd0);
    mem_rdata  = 32'h1234_9ABC;
    mem_rvalid = 1'b1;
    exp_q.push_back('{addr: 5'd4, data: 32'hFFFF_9ABC});
    tick();
    mem_rvalid = 1'b0;
    chk("mis_addr", {27'd0, mux_addr}, 32'd4);
    chk("mis_err", {31'd0, err}, 32'd1);
    tick();

    // Spurious rvalid right after reset.
    do_reset();
    mem_rdata  = 32'h5555_AAAA;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("spur_err", {31'd0, err}, 32'd1);
    chk("spur_addr", {27'd0, mux_addr}, 32'd0);
    chk("spur_stall", {31'd0, stall}, 32'd0);
    chk("spur_retire", retire_count, 32'd0);
    tick();
    chk("spur_addr_after", {27'd0, mux_addr}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
